// File: rtl/ofdm_symbol_extractor.sv
// OFDM symbol extractor: after a PSS peak, skips to the first symbol, strips the
// cyclic prefix and forwards FFT_LEN samples per symbol. Optional: OFDM_SYMBOL_EXTRACTOR_RESYNC_EN.
module ofdm_symbol_extractor #(
  parameter int IN_DW        = 32,
  parameter int FFT_LEN      = 256,
  parameter int CP_LEN       = 18,
  parameter int START_OFFSET = FFT_LEN + 2*CP_LEN - 13,
  parameter int NUM_SYMBOLS  = 4
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [IN_DW-1:0] s_axis_in_tdata,
  input  logic             s_axis_in_tvalid,
  input  logic             peak_detected_i,
  output logic [IN_DW-1:0] m_axis_out_tdata,
  output logic             m_axis_out_tvalid,
  output logic             m_axis_out_tlast,
  output logic [3:0]       symbol_index_o,
  output logic             busy_o
`ifdef OFDM_SYMBOL_EXTRACTOR_RESYNC_EN
  ,
  output logic [7:0]       resync_count_o
`endif
);

  localparam int CNT_MAX0 = (START_OFFSET > FFT_LEN) ? START_OFFSET : FFT_LEN;
  localparam int CNT_MAX  = (CP_LEN > CNT_MAX0) ? CP_LEN : CNT_MAX0;
  localparam int CW       = $clog2(CNT_MAX + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SKIP   = 2'd1;
  localparam logic [1:0] S_SYMBOL = 2'd2;
  localparam logic [1:0] S_CP     = 2'd3;

  // Count at which the discarded skip/CP sample ends its phase.
  localparam logic [CW-1:0] SKIP_LAST = CW'((START_OFFSET >= 2) ? START_OFFSET - 2 : 0);
  localparam logic [CW-1:0] CP_LAST   = CW'((CP_LEN >= 1) ? CP_LEN - 1 : 0);
  localparam logic [CW-1:0] SYM_LAST  = CW'(FFT_LEN - 1);
  localparam logic [3:0]    IDX_LAST  = 4'(NUM_SYMBOLS - 1);

  localparam logic [1:0] START_STATE  = (START_OFFSET == 1) ? S_SYMBOL : S_SKIP;
  localparam logic [1:0] AFTER_SYMBOL = (CP_LEN == 0) ? S_SYMBOL : S_CP;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    sym_q, sym_d;
  logic          out_vld_d, out_last_d;

`ifdef OFDM_SYMBOL_EXTRACTOR_RESYNC_EN
  logic       pend_q, pend_d;
  logic       resync_take;
  logic [7:0] resync_cnt_q;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sym_d      = sym_q;
    out_vld_d  = 1'b0;
    out_last_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The peak-cycle sample is never counted.
        if (peak_detected_i) begin
          state_d = START_STATE;
          cnt_d   = '0;
          sym_d   = '0;
        end
      end
      S_SKIP: begin
        if (s_axis_in_tvalid) begin
          if (cnt_q == SKIP_LAST) begin
            state_d = S_SYMBOL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_SYMBOL: begin
        if (s_axis_in_tvalid) begin
          out_vld_d  = 1'b1;
          out_last_d = (cnt_q == SYM_LAST);
          if (cnt_q == SYM_LAST) begin
            cnt_d = '0;
            if (sym_q == IDX_LAST) begin
              state_d = S_IDLE;
            end else begin
              state_d = AFTER_SYMBOL;
              sym_d   = sym_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        if (s_axis_in_tvalid) begin
          if (cnt_q == CP_LAST) begin
            state_d = S_SYMBOL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
    endcase

`ifdef OFDM_SYMBOL_EXTRACTOR_RESYNC_EN
    // SKIP/CP restart at once; a peak inside a symbol waits for its tlast sample.
    resync_take = (peak_detected_i && (state_q == S_SKIP || state_q == S_CP)) ||
                  ((pend_q || peak_detected_i) && out_last_d);
    pend_d = pend_q;
    if (resync_take)
      pend_d = 1'b0;
    else if (peak_detected_i && state_q == S_SYMBOL)
      pend_d = 1'b1;
    if (resync_take) begin
      state_d = START_STATE;
      cnt_d   = '0;
      sym_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sym_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      m_axis_out_tdata  <= '0;
      m_axis_out_tvalid <= 1'b0;
      m_axis_out_tlast  <= 1'b0;
      symbol_index_o    <= '0;
    end else begin
      m_axis_out_tvalid <= out_vld_d;
      m_axis_out_tlast  <= out_last_d;
      if (out_vld_d) begin
        m_axis_out_tdata <= s_axis_in_tdata;
        symbol_index_o   <= sym_q;
      end
    end
  end

  assign busy_o = (state_q != S_IDLE);

`ifdef OFDM_SYMBOL_EXTRACTOR_RESYNC_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pend_q       <= 1'b0;
      resync_cnt_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (resync_take && resync_cnt_q != 8'hFF)
        resync_cnt_q <= resync_cnt_q + 8'd1;
    end
  end

  assign resync_count_o = resync_cnt_q;
`endif

endmodule

// File: doc/ofdm_symbol_extractor.md
Name: ofdm_symbol_extractor

Overview:
- Sits between the PSS peak detector and the FFT.
- After a PSS peak, it counts input samples to the start of the next OFDM symbol, strips the cyclic prefix and forwards exactly FFT_LEN samples per symbol, with a last flag, for NUM_SYMBOLS consecutive symbols.
- Replaces free-running wait counters with a sample-accurate, valid-qualified sequencer that also drives the FFT clock enable.

Parameters:
- IN_DW, 32: complex sample width; imag in upper half, real in lower half.
- FFT_LEN, 256: useful samples per symbol (power of two).
- CP_LEN, 18: cyclic-prefix samples discarded before each symbol after the first.
- START_OFFSET, 279: index of the first output sample, counted in valid samples after the peak cycle. Default is FFT_LEN + 2*CP_LEN - 13. Must be ≥ 1.
- NUM_SYMBOLS, 4: symbols extracted per peak, range 1..15.

Ports:
- clk_i, in, 1: clock.
- reset_ni, in, 1: asynchronous, active-low reset.
- s_axis_in_tdata, in, IN_DW: input sample stream (decimated-rate domain of the FFT input).
- s_axis_in_tvalid, in, 1: input sample valid; there is no backpressure.
- peak_detected_i, in, 1: single-cycle pulse from the peak detector.
- m_axis_out_tdata, out, IN_DW: extracted sample.
- m_axis_out_tvalid, out, 1: extracted sample valid; feeds the FFT clock enable.
- m_axis_out_tlast, out, 1: high on the last sample (sample FFT_LEN-1) of each symbol.
- symbol_index_o, out, 4: index of the symbol currently being output, 0..NUM_SYMBOLS-1.
- busy_o, out, 1: high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, reset_ni=0):
  - State goes to IDLE.
  - All counters clear to 0.
  - m_axis_out_tdata, m_axis_out_tvalid, m_axis_out_tlast, symbol_index_o and busy_o all go to 0.
  - Reset mid-symbol aborts the symbol; there is no partial tlast.
- States: IDLE, SKIP, SYMBOL, CP.
- Sample counter: cnt, width clog2(max(START_OFFSET, FFT_LEN) + 1). It advances only on cycles with s_axis_in_tvalid=1.
- IDLE:
  - On peak_detected_i=1: go to SKIP with cnt=0 and symbol index = 0.
  - The sample present in the peak cycle is not counted, even if valid.
- SKIP:
  - Each valid sample increments cnt.
  - The valid sample at which cnt reaches START_OFFSET-1 is discarded. The state then goes to SYMBOL with cnt=0, so the next valid sample is the START_OFFSET-th sample after the peak.
  - Special case START_OFFSET=1: the state goes directly from IDLE to SYMBOL.
- SYMBOL:
  - Each valid input sample is registered to the output one cycle later, with m_axis_out_tvalid=1. Latency is exactly 1 cycle; the valid gap pattern is preserved.
  - tlast is asserted with sample cnt = FFT_LEN-1.
  - After that sample:
    - If symbol index = NUM_SYMBOLS-1: go to IDLE.
    - Otherwise: increment symbol index, cnt=0, go to CP.
- CP:
  - CP_LEN valid samples are discarded, then the state goes to SYMBOL.
  - If CP_LEN=0, SYMBOL goes directly to the next SYMBOL.
- m_axis_out_tvalid is 0 in every cycle except the registered SYMBOL samples.
- m_axis_out_tdata holds its last value when m_axis_out_tvalid=0.
- symbol_index_o is registered alongside tdata, so it is aligned with the output sample.
- busy_o is high in SKIP, SYMBOL and CP.
- Peak while busy (macro undefined): the peak is ignored and the sequence continues unchanged.
- Peak in the same cycle as the final tlast sample: ignored. The block returns to IDLE, and a new peak is needed on a later cycle.
- Invalid input cycles never change state or counters, except for the peak transition out of IDLE.

Optional Feature:
- Macro: OFDM_SYMBOL_EXTRACTOR_RESYNC_EN.
- When defined:
  - A peak_detected_i pulse in SKIP or CP restarts the sequence exactly as from IDLE: SKIP, cnt=0, symbol index = 0.
  - A peak in SYMBOL is deferred. It is latched and applied when that symbol's tlast sample is consumed, so no truncated symbol is ever emitted to the FFT.
  - At most one deferred peak is held; later pulses overwrite it.
  - Output resync_count_o [7:0] counts applied resyncs. It saturates at 255 and is reset to 0.
- When undefined: peaks while busy are ignored, and the port and logic are absent.

Test Plan:

All scenarios use FFT_LEN=8, CP_LEN=2, START_OFFSET=3, NUM_SYMBOLS=2. The input data value equals the valid-sample number after the peak; the peak-cycle sample is 0.

1. Continuous valid, one peak:
   - Output 3..10 with tlast on 10 and symbol_index_o=0.
   - Then 13..20 with tlast on 20 and symbol_index_o=1.
   - busy_o returns to 0 the cycle after 20 is consumed.
   - Exactly 16 output valids in total.
2. tvalid toggling 1,0,1,0, one peak:
   - Same data sequence as scenario 1.
   - Each output appears 1 cycle after its input, with gaps reproduced.
3. Reset asserted asynchronously mid-symbol 0 (after output 6):
   - All outputs go to 0 immediately.
   - No further valids until the next peak.
   - After a new peak the sequence restarts at value 3.
4. Second peak during CP (macro undefined):
   - Ignored; output identical to scenario 1.
5. Second peak during CP (macro defined):
   - Counting restarts: the next output is the 3rd valid sample after the second peak.
   - resync_count_o=1.
6. Peak during SYMBOL (macro defined):
   - Symbol 0 completes through value 10 with tlast.
   - Then SKIP restarts; no CP is skipped.
   - resync_count_o=1.
